// File: rtl/pipe_interlock_pkg.sv
// Shared constants for the pipeline interlock: forward-select codes, register-zero
// index, in-flight entry bit layout and default parameter values.
package pipe_interlock_pkg;

    localparam int REG_AW_DEF   = 5;
    localparam int WB_LAT_DEF   = 3;
    localparam int LOAD_LAT_DEF = 2;
    localparam int FWD_EN_DEF   = 1;
    localparam int BR_FLUSH_DEF = 2;
    localparam int CNT_W_DEF    = 16;

    localparam int FWD_W = 2;
    localparam logic [FWD_W-1:0] FWD_RF = '0;
    localparam int REG_ZERO = 0;

    // In-flight entry: {rd, load, wen, valid}, rd occupies the top REG_AW bits
    localparam int ENT_VALID  = 0;
    localparam int ENT_WEN    = 1;
    localparam int ENT_LOAD   = 2;
    localparam int ENT_RD_LSB = 3;

    function automatic int ent_width(input int reg_aw);
        return reg_aw + ENT_RD_LSB;
    endfunction

endpackage

// File: rtl/pipe_interlock_if.sv
// ID-stage side-band bundle between the pipeline (master) and the interlock unit (slave).
interface pipe_interlock_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) ();
    import pipe_interlock_pkg::*;

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic              id_rs_use;
    logic [REG_AW-1:0] id_rt;
    logic              id_rt_use;
    logic [REG_AW-1:0] id_rd;
    logic              id_wen;
    logic              id_load;
    logic              br_taken;
    logic              stall;
    logic              flush;
    logic [FWD_W-1:0]  fwd_a;
    logic [FWD_W-1:0]  fwd_b;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs, id_rs_use, id_rt, id_rt_use, id_rd, id_wen, id_load, br_taken,
        input  stall, flush, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rs_use, id_rt, id_rt_use, id_rd, id_wen, id_load, br_taken,
        output stall, flush, fwd_a, fwd_b, stall_cnt
    );

endinterface

// File: rtl/pipe_interlock_inflight_sb.sv
// In-flight producer table (slot1 = EX ... slot WB_LAT = WB) with a youngest-match
// search per source operand. The WB slot is kept only to model the drop-out point.
module pipe_interlock_inflight_sb
    import pipe_interlock_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int WB_LAT = WB_LAT_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_issue,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_wen,
    input  logic              i_load,
    input  logic [REG_AW-1:0] i_src_a,
    input  logic [REG_AW-1:0] i_src_b,
    output logic              o_match_a,
    output logic [FWD_W-1:0]  o_slot_a,
    output logic              o_load_a,
    output logic              o_match_b,
    output logic [FWD_W-1:0]  o_slot_b,
    output logic              o_load_b
);

    localparam int EW = ent_width(REG_AW);

    logic [EW-1:0] r_slot [1:WB_LAT];
    logic [EW-1:0] w_new;

    function automatic logic slot_hit(input logic [EW-1:0] e, input logic [REG_AW-1:0] s);
        return e[ENT_VALID] & e[ENT_WEN] & (e[ENT_RD_LSB +: REG_AW] == s);
    endfunction

    always_comb begin
        w_new = '0;
        if (i_issue) begin
            w_new[ENT_VALID]             = 1'b1;
            w_new[ENT_WEN]               = i_wen;
            w_new[ENT_LOAD]              = i_load;
            w_new[ENT_RD_LSB +: REG_AW]  = i_rd;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 1; k <= WB_LAT; k++) r_slot[k] <= '0;
        end else begin
            r_slot[1] <= w_new;
            for (int k = 2; k <= WB_LAT; k++) r_slot[k] <= r_slot[k-1];
        end
    end

    // Scan oldest to youngest so the lowest matching slot overwrites the result.
    always_comb begin
        o_match_a = 1'b0;
        o_slot_a  = FWD_RF;
        o_load_a  = 1'b0;
        o_match_b = 1'b0;
        o_slot_b  = FWD_RF;
        o_load_b  = 1'b0;
        for (int k = WB_LAT - 1; k >= 1; k--) begin
            if (slot_hit(r_slot[k], i_src_a)) begin
                o_match_a = 1'b1;
                o_slot_a  = FWD_W'(k);
                o_load_a  = r_slot[k][ENT_LOAD];
            end
            if (slot_hit(r_slot[k], i_src_b)) begin
                o_match_b = 1'b1;
                o_slot_b  = FWD_W'(k);
                o_load_b  = r_slot[k][ENT_LOAD];
            end
        end
    end

endmodule

// File: rtl/pipe_interlock.sv
// Hazard/interlock unit beside ID: stalls only on RAW hazards that forwarding cannot
// cover, drives EX forward selects and squashes wrong-path slots after a taken branch.
module pipe_interlock
    import pipe_interlock_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int WB_LAT   = WB_LAT_DEF,
    parameter int LOAD_LAT = LOAD_LAT_DEF,
    parameter int FWD_EN   = FWD_EN_DEF,
    parameter int BR_FLUSH = BR_FLUSH_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    pipe_interlock_if.slave bus
);

    localparam int FLUSH_W = $clog2(BR_FLUSH) + 1;

    logic [FLUSH_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic             w_match_a, w_match_b;
    logic             w_load_a, w_load_b;
    logic [FWD_W-1:0] w_slot_a, w_slot_b;
    logic             w_use_a, w_use_b;
    logic             w_hz_a, w_hz_b;
    logic             w_flush, w_stall, w_issue;

    pipe_interlock_inflight_sb #(
        .REG_AW (REG_AW),
        .WB_LAT (WB_LAT)
    ) u_sb (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_issue   (w_issue),
        .i_rd      (bus.id_rd),
        .i_wen     (bus.id_wen),
        .i_load    (bus.id_load),
        .i_src_a   (bus.id_rs),
        .i_src_b   (bus.id_rt),
        .o_match_a (w_match_a),
        .o_slot_a  (w_slot_a),
        .o_load_a  (w_load_a),
        .o_match_b (w_match_b),
        .o_slot_b  (w_slot_b),
        .o_load_b  (w_load_b)
    );

    assign w_use_a = bus.id_rs_use & (bus.id_rs != REG_AW'(REG_ZERO));
    assign w_use_b = bus.id_rt_use & (bus.id_rt != REG_AW'(REG_ZERO));

    // A matched producer is a hazard when forwarding is off or a load has not yet
    // reached the first slot that can supply its data.
    assign w_hz_a = w_use_a & w_match_a &
                    ((FWD_EN == 0) | (w_load_a & (int'(w_slot_a) < LOAD_LAT)));
    assign w_hz_b = w_use_b & w_match_b &
                    ((FWD_EN == 0) | (w_load_b & (int'(w_slot_b) < LOAD_LAT)));

    assign w_flush = bus.br_taken | (r_flush_cnt != '0);
    assign w_stall = bus.id_valid & (w_hz_a | w_hz_b) & ~w_flush;
    assign w_issue = bus.id_valid & ~w_stall & ~w_flush;

    assign bus.stall     = w_stall;
    assign bus.flush     = w_flush;
    assign bus.fwd_a     = (w_use_a & w_match_a & ~w_hz_a) ? w_slot_a : FWD_RF;
    assign bus.fwd_b     = (w_use_b & w_match_b & ~w_hz_b) ? w_slot_b : FWD_RF;
    assign bus.stall_cnt = r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (bus.br_taken)
                r_flush_cnt <= FLUSH_W'(BR_FLUSH - 1);
            else if (r_flush_cnt != '0)
                r_flush_cnt <= r_flush_cnt - 1'b1;

            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_interlock.sv
// Directed bench: dut0 is the default forwarding configuration, dut1 has forwarding
// disabled and a 2-bit stall counter so saturation is reachable quickly.
module tb_pipe_interlock;
    import pipe_interlock_pkg::*;

    logic clk;
    logic rst_n;

    logic       v, rsu, rtu, wen, ld, br;
    logic [4:0] rs, rt, rd;

    int checks = 0;
    int errors = 0;

    pipe_interlock_if #(.REG_AW(5), .CNT_W(16)) if0 ();
    pipe_interlock_if #(.REG_AW(5), .CNT_W(2))  if1 ();

    assign if0.id_valid  = v;   assign if1.id_valid  = v;
    assign if0.id_rs     = rs;  assign if1.id_rs     = rs;
    assign if0.id_rs_use = rsu; assign if1.id_rs_use = rsu;
    assign if0.id_rt     = rt;  assign if1.id_rt     = rt;
    assign if0.id_rt_use = rtu; assign if1.id_rt_use = rtu;
    assign if0.id_rd     = rd;  assign if1.id_rd     = rd;
    assign if0.id_wen    = wen; assign if1.id_wen    = wen;
    assign if0.id_load   = ld;  assign if1.id_load   = ld;
    assign if0.br_taken  = br;  assign if1.br_taken  = br;

    pipe_interlock #(
        .REG_AW(5), .WB_LAT(3), .LOAD_LAT(2), .FWD_EN(1), .BR_FLUSH(2), .CNT_W(16)
    ) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if0)
    );

    pipe_interlock #(
        .REG_AW(5), .WB_LAT(3), .LOAD_LAT(2), .FWD_EN(0), .BR_FLUSH(2), .CNT_W(2)
    ) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic iv, input logic [4:0] irs, input logic irsu,
                          input logic [4:0] irt, input logic irtu, input logic [4:0] ird,
                          input logic iwen, input logic ild);
        v = iv; rs = irs; rsu = irsu; rt = irt; rtu = irtu; rd = ird; wen = iwen; ld = ild;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        br    = 1'b0;
        idle();

        // Reset
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_hold_stall", if0.stall, 1'b0);
        chk("rst_hold_flush", if0.flush, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_stall", if0.stall, 1'b0);
        chk("rst_flush", if0.flush, 1'b0);
        chk("rst_fwd_a", if0.fwd_a, 2'd0);
        chk("rst_fwd_b", if0.fwd_b, 2'd0);
        chk("rst_cnt", if0.stall_cnt, 16'd0);
        chk("rst_cnt_nofwd", if1.stall_cnt, 2'd0);
        tick();

        // Back-to-back ALU forwarding
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
        @(negedge clk);
        chk("alu0_stall", if0.stall, 1'b0);
        chk("alu0_fwd_a", if0.fwd_a, 2'd0);
        tick();
        set_id(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0);
        @(negedge clk);
        chk("alu1_stall", if0.stall, 1'b0);
        chk("alu1_fwd_a", if0.fwd_a, 2'd1);
        chk("alu1_fwd_b", if0.fwd_b, 2'd1);
        tick();
        set_id(1, 5'd3, 1, 5'd3, 1, 5'd5, 1, 0);
        @(negedge clk);
        chk("alu2_stall", if0.stall, 1'b0);
        chk("alu2_fwd_a", if0.fwd_a, 2'd2);
        chk("alu2_fwd_b", if0.fwd_b, 2'd2);
        tick();
        set_id(1, 5'd3, 1, 5'd0, 0, 5'd6, 1, 0);
        @(negedge clk);
        chk("wb_slot_fwd_a", if0.fwd_a, 2'd0);
        chk("wb_slot_stall", if0.stall, 1'b0);
        tick();
        drain();

        // Load-use
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
        @(negedge clk);
        chk("lw_stall", if0.stall, 1'b0);
        tick();
        set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
        @(negedge clk);
        chk("lu_stall1", if0.stall, 1'b1);
        tick();
        @(negedge clk);
        chk("lu_stall2", if0.stall, 1'b0);
        chk("lu_fwd_a", if0.fwd_a, 2'd2);
        chk("lu_fwd_b", if0.fwd_b, 2'd0);
        chk("lu_cnt", if0.stall_cnt, 16'd1);
        tick();
        drain();

        // Reset during a stall
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
        tick();
        set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
        @(negedge clk);
        chk("mid_stall", if0.stall, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", if0.stall, 1'b0);
        chk("mid_rst_cnt", if0.stall_cnt, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_stall", if0.stall, 1'b0);
        tick();
        drain();

        // Forwarding disabled (dut1)
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
        @(negedge clk);
        chk("nf_prod_stall", if1.stall, 1'b0);
        tick();
        set_id(1, 5'd3, 1, 5'd2, 1, 5'd7, 1, 0);
        @(negedge clk);
        chk("nf_stall1", if1.stall, 1'b1);
        chk("fw_nostall", if0.stall, 1'b0);
        chk("fw_fwd_a", if0.fwd_a, 2'd1);
        chk("fw_fwd_b", if0.fwd_b, 2'd0);
        tick();
        @(negedge clk);
        chk("nf_stall2", if1.stall, 1'b1);
        tick();
        @(negedge clk);
        chk("nf_stall3", if1.stall, 1'b0);
        chk("nf_fwd_a", if1.fwd_a, 2'd0);
        chk("nf_fwd_b", if1.fwd_b, 2'd0);
        chk("nf_cnt", if1.stall_cnt, 2'd2);
        tick();
        drain();

        // Taken branch over a stalling ID
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
        tick();
        set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
        br = 1'b1;
        @(negedge clk);
        chk("br_flush1", if0.flush, 1'b1);
        chk("br_stall1", if0.stall, 1'b0);
        tick();
        br = 1'b0;
        @(negedge clk);
        chk("br_flush2", if0.flush, 1'b1);
        chk("br_stall2", if0.stall, 1'b0);
        tick();
        set_id(1, 5'd6, 1, 5'd6, 1, 5'd9, 1, 0);
        @(negedge clk);
        chk("br_flush3", if0.flush, 1'b0);
        chk("br_squash_stall", if0.stall, 1'b0);
        chk("br_squash_fwd_a", if0.fwd_a, 2'd0);
        chk("br_squash_fwd_b", if0.fwd_b, 2'd0);
        chk("br_cnt", if0.stall_cnt, 16'd0);
        tick();

        // Branch during an active flush reloads the count
        idle();
        br = 1'b1;
        @(negedge clk);
        chk("rl_flush1", if0.flush, 1'b1);
        tick();
        tick();
        br = 1'b0;
        @(negedge clk);
        chk("rl_flush3", if0.flush, 1'b1);
        tick();
        @(negedge clk);
        chk("rl_flush4", if0.flush, 1'b0);
        drain();

        // r0 and unused sources
        set_id(1, 5'd10, 1, 5'd11, 1, 5'd0, 1, 0);
        @(negedge clk);
        chk("r0_prod_stall", if0.stall, 1'b0);
        tick();
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd1, 1, 0);
        @(negedge clk);
        chk("r0_stall", if0.stall, 1'b0);
        chk("r0_fwd_a", if0.fwd_a, 2'd0);
        chk("r0_fwd_b", if0.fwd_b, 2'd0);
        chk("r0_stall_nf", if1.stall, 1'b0);
        tick();
        set_id(1, 5'd10, 1, 5'd11, 1, 5'd2, 1, 0);
        tick();
        set_id(1, 5'd9, 1, 5'd2, 0, 5'd7, 1, 0);
        @(negedge clk);
        chk("nouse_stall", if0.stall, 1'b0);
        chk("nouse_fwd_a", if0.fwd_a, 2'd0);
        chk("nouse_fwd_b", if0.fwd_b, 2'd0);
        chk("nouse_stall_nf", if1.stall, 1'b0);
        tick();
        drain();

        // Stall counter saturation on the 2-bit counter
        set_id(1, 5'd10, 1, 5'd11, 1, 5'd3, 1, 0);
        tick();
        set_id(1, 5'd3, 1, 5'd2, 1, 5'd7, 1, 0);
        tick();
        tick();
        @(negedge clk);
        chk("sat_stall", if1.stall, 1'b0);
        chk("sat_cnt", if1.stall_cnt, 2'd3);
        chk("sat_cnt_fw", if0.stall_cnt, 16'd0);
        tick();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
